// File: rtl/prbs_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_pattern_gen : serial test-pattern source, preamble then PRBS7/15/23/31 |
// | with valid/ready handshake. Optional PRBS_ERR_INJ_EN adds error injection. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module prbs_pattern_gen #(
  parameter int                    PREAMBLE_W = 32,
  parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 32'hCCDDEEFF,
  parameter int                    N_REP      = 2,
  parameter logic [30:0]           SEED       = {31{1'b1}}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  poly_sel,
  input  logic        data_ready,
`ifdef PRBS_ERR_INJ_EN
  input  logic        err_inj,
  output logic [15:0] err_cnt,
`endif
  output logic        data_out,
  output logic        data_valid,
  output logic        in_preamble,
  output logic        frame_start
);

  localparam int c_BIT_W = (PREAMBLE_W > 1) ? $clog2(PREAMBLE_W) : 1;
  localparam int c_REP_W = (N_REP > 0) ? $clog2(N_REP + 1) : 1;
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(PREAMBLE_W - 1);
  localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'((N_REP > 0) ? (N_REP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_PRBS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_poly;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic [c_REP_W-1:0]    r_rep_cnt;
  logic [30:0]           r_lfsr;
  logic [PREAMBLE_W-1:0] r_shift;
  logic [PREAMBLE_W-1:0] w_shift_rot;
  logic                  r_frame_start;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_pre_last;
  logic                  w_fb;
  logic                  w_msb;
  logic                  w_inv;

  assign w_accept   = data_valid & data_ready;
  assign w_load     = (r_state == ST_IDLE) & start & ~stop;
  assign w_pre_last = (r_bit_cnt == c_BIT_LAST) && (r_rep_cnt == c_REP_LAST);

  // Rotating the shifter brings it back to PREAMBLE after every full word.
  generate
    if (PREAMBLE_W > 1) begin : g_rot_multi
      assign w_shift_rot = {r_shift[PREAMBLE_W-2:0], r_shift[PREAMBLE_W-1]};
    end else begin : g_rot_single
      assign w_shift_rot = r_shift;
    end
  endgenerate

  always_comb begin
    w_fb  = 1'b0;
    w_msb = 1'b0;
    case (r_poly)
      2'b00: begin w_fb = r_lfsr[6]  ^ r_lfsr[5];  w_msb = r_lfsr[6];  end
      2'b01: begin w_fb = r_lfsr[14] ^ r_lfsr[13]; w_msb = r_lfsr[14]; end
      2'b10: begin w_fb = r_lfsr[22] ^ r_lfsr[17]; w_msb = r_lfsr[22]; end
      default: begin w_fb = r_lfsr[30] ^ r_lfsr[27]; w_msb = r_lfsr[30]; end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_state_nxt = (N_REP == 0) ? ST_PRBS : ST_PRE;
        ST_PRE:  if (w_accept && w_pre_last) w_state_nxt = ST_PRBS;
        ST_PRBS: w_state_nxt = ST_PRBS;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_poly        <= 2'b00;
      r_bit_cnt     <= '0;
      r_rep_cnt     <= '0;
      r_lfsr        <= SEED;
      r_shift       <= PREAMBLE;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_start <= w_load;
      if (w_load) begin
        r_poly    <= poly_sel;
        r_bit_cnt <= '0;
        r_rep_cnt <= '0;
        r_lfsr    <= SEED;
        r_shift   <= PREAMBLE;
      end else if (w_accept && (r_state == ST_PRE)) begin
        r_shift <= w_shift_rot;
        if (r_bit_cnt == c_BIT_LAST) begin
          r_bit_cnt <= '0;
          r_rep_cnt <= r_rep_cnt + c_REP_W'(1);
        end else begin
          r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
        end
      end else if (w_accept && (r_state == ST_PRBS)) begin
        r_lfsr <= {r_lfsr[29:0], w_fb};
      end
    end
  end

`ifdef PRBS_ERR_INJ_EN
  logic        r_inv;
  logic [15:0] r_err_cnt;

  // Inversion applies to the presented bit only; the LFSR keeps the clean sequence.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inv     <= 1'b0;
      r_err_cnt <= 16'h0000;
    end else if (w_load) begin
      r_inv     <= 1'b0;
      r_err_cnt <= 16'h0000;
    end else if (w_accept && (r_state == ST_PRBS)) begin
      r_inv <= err_inj;
      if (err_inj && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign w_inv   = r_inv;
  assign err_cnt = r_err_cnt;
`else
  assign w_inv = 1'b0;
`endif

  assign data_valid  = (r_state != ST_IDLE);
  assign in_preamble = (r_state == ST_PRE);
  assign frame_start = r_frame_start;
  assign data_out    = (r_state == ST_PRE)  ? r_shift[PREAMBLE_W-1] :
                       (r_state == ST_PRBS) ? (w_msb ^ w_inv) : 1'b0;

endmodule
`default_nettype wire
